csa_resolve_20: RTL and testbench

- Converts carry-save accumulator limbs (C, S pairs from the 9-input CSA compressor trees) back into non-redundant 16-bit digits.
- Limbs arrive least-significant first as a framed valid/ready stream. Each limb is added with the carry out of the previous limb.
- Sits between the CSA reduction stage and the digit-serial modular reduction / output path.

---
 rtl/csa_pkg.sv | 15 +
 rtl/csa_resolve_step.sv | 27 ++
 rtl/csa_resolve_20.sv | 113 +++++++++++
 tb/tb_csa_resolve_20.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save resolve path: default widths and the
// frame-tracking state encoding used by csa_resolve_20.
package csa_pkg;

  localparam int CSA_IN_W    = 20;
  localparam int CSA_DIG_W   = 16;
  localparam int CSA_CARRY_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } resolve_state_e;

endpackage

// File: rtl/csa_resolve_step.sv
// One limb of carry-save resolution: adds the C and S words of a limb to the
// carry from the previous limb and splits the result into a digit and the
// carry into the next limb. Purely combinational so a wider variant can chain
// several of these in one cycle.
module csa_resolve_step #(
  parameter int IN_W    = 20,
  parameter int DIG_W   = 16,
  parameter int CARRY_W = 6
) (
  input  logic [IN_W-1:0]    c,
  input  logic [IN_W-1:0]    s,
  input  logic [CARRY_W-1:0] carry_in,
  output logic [DIG_W-1:0]   digit,
  output logic [CARRY_W-1:0] carry_next
);

  // Two IN_W words plus a narrow carry never exceed IN_W+2 bits.
  logic [IN_W+1:0] sum;

  // Full-width add, then split at the digit boundary.
  always_comb begin
    sum        = (IN_W+2)'(c) + (IN_W+2)'(s) + (IN_W+2)'(carry_in);
    digit      = sum[DIG_W-1:0];
    carry_next = CARRY_W'(sum >> DIG_W);
  end

endmodule

// File: rtl/csa_resolve_20.sv
// Carry-save to non-redundant digit converter. Limbs arrive LS-first as a
// framed valid/ready stream; each limb is resolved with the running carry and
// emitted as one DIG_W digit through a single output register. The carry out
// of the top limb is either emitted as an extra digit or reported on out_carry.
module csa_resolve_20
  import csa_pkg::*;
#(
  parameter int IN_W       = CSA_IN_W,
  parameter int DIG_W      = CSA_DIG_W,
  parameter int CARRY_W    = CSA_CARRY_W,
  parameter int EMIT_FINAL = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_c,
  input  logic [IN_W-1:0]    in_s,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DIG_W-1:0]   out_digit,
  output logic               out_last,
  output logic [CARRY_W-1:0] out_carry,
  output logic               busy
);

  // The carry register must hold the largest inter-limb carry, and the final
  // carry must fit in one digit so the flush digit can never overflow.
  if ((CARRY_W < IN_W + 2 - DIG_W) || (CARRY_W > DIG_W)) begin : g_bad_carry_w
    $error("csa_resolve_20: CARRY_W must satisfy IN_W+2-DIG_W <= CARRY_W <= DIG_W");
  end

  resolve_state_e     state;
  logic [CARRY_W-1:0] carry_q;
  logic [DIG_W-1:0]   digit_p1;
  logic               last_p1;
  logic               vld_p1;
  logic [CARRY_W-1:0] carry_out_q;

  logic [DIG_W-1:0]   step_digit;
  logic [CARRY_W-1:0] step_carry;
  logic               out_free;
  logic               accept;

  csa_resolve_step #(
    .IN_W    (IN_W),
    .DIG_W   (DIG_W),
    .CARRY_W (CARRY_W)
  ) u_step (
    .c          (in_c),
    .s          (in_s),
    .carry_in   (carry_q),
    .digit      (step_digit),
    .carry_next (step_carry)
  );

  // Output register can take a new digit if empty or being drained this cycle;
  // FLUSH blocks input so the pending carry digit goes out first.
  always_comb begin
    out_free = !vld_p1 || out_ready;
    in_ready = (state != FLUSH) && out_free;
    accept   = in_valid && in_ready;
  end

  // ---- stage p0 -> p1: frame FSM, carry chain and output digit register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      carry_q     <= '0;
      vld_p1      <= 1'b0;
      digit_p1    <= '0;
      last_p1     <= 1'b0;
      carry_out_q <= '0;
    end else begin
      if (vld_p1 && out_ready) begin
        vld_p1 <= 1'b0;
      end
      if (accept) begin
        digit_p1 <= step_digit;
        vld_p1   <= 1'b1;
        carry_q  <= step_carry;
        if (!in_last) begin
          last_p1 <= 1'b0;
          state   <= RUN;
        end else if (EMIT_FINAL != 0) begin
          last_p1 <= 1'b0;
          state   <= FLUSH;
        end else begin
          last_p1     <= 1'b1;
          carry_out_q <= step_carry;
          carry_q     <= '0;
          state       <= IDLE;
        end
      end else if ((state == FLUSH) && out_free) begin
        // Final carry goes out as its own digit, even when it is zero.
        digit_p1    <= DIG_W'(carry_q);
        last_p1     <= 1'b1;
        vld_p1      <= 1'b1;
        carry_out_q <= carry_q;
        carry_q     <= '0;
        state       <= IDLE;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_digit = digit_p1;
  assign out_last  = last_p1;
  assign out_carry = carry_out_q;
  assign busy      = (state != IDLE) || vld_p1;

endmodule

// File: tb/tb_csa_resolve_20.sv
// Scoreboard bench for csa_resolve_20. Two instances (final carry emitted /
// not emitted) share stimulus; 'sel' picks which one is active. Expected
// digits are the base-2^16 digits of the whole frame value.
module tb_csa_resolve_20;

  typedef struct packed {
    logic [15:0] digit;
    logic        last;
    logic [5:0]  carry;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        in_valid;
  logic [19:0] in_c;
  logic [19:0] in_s;
  logic        in_last;
  logic        out_ready;

  logic        in_ready, out_valid, out_last, busy;
  logic [15:0] out_digit;
  logic [5:0]  out_carry;

  logic        rdy1, ov1, ol1, bz1;
  logic [15:0] od1;
  logic [5:0]  oc1;
  logic        rdy0, ov0, ol0, bz0;
  logic [15:0] od0;
  logic [5:0]  oc0;

  csa_resolve_20 #(.IN_W(20), .DIG_W(16), .CARRY_W(6), .EMIT_FINAL(1)) dut_emit (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel), .in_ready(rdy1),
    .in_c(in_c), .in_s(in_s), .in_last(in_last), .out_valid(ov1),
    .out_ready(out_ready), .out_digit(od1), .out_last(ol1), .out_carry(oc1),
    .busy(bz1)
  );

  csa_resolve_20 #(.IN_W(20), .DIG_W(16), .CARRY_W(6), .EMIT_FINAL(0)) dut_noemit (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !sel), .in_ready(rdy0),
    .in_c(in_c), .in_s(in_s), .in_last(in_last), .out_valid(ov0),
    .out_ready(out_ready), .out_digit(od0), .out_last(ol0), .out_carry(oc0),
    .busy(bz0)
  );

  assign in_ready  = sel ? rdy1 : rdy0;
  assign out_valid = sel ? ov1 : ov0;
  assign out_digit = sel ? od1 : od0;
  assign out_last  = sel ? ol1 : ol0;
  assign out_carry = sel ? oc1 : oc0;
  assign busy      = sel ? bz1 : bz0;

  int   n_cmp;
  int   n_fail;
  int   cyc;
  int   or_mode;
  int   gap_max;
  logic mon_en;
  exp_t exp_q[$];
  int   hs_cyc[$];
  logic [19:0] fc[8];
  logic [19:0] fs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // out_ready driver: 0 = always ready, 1 = random, 2 = stalled
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output handshake and checks that a
  // stalled digit stays put.
  initial begin
    logic        hold;
    logic [15:0] hold_digit;
    logic        hold_last;
    exp_t        e;
    hold = 1'b0;
    hold_digit = '0;
    hold_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en || !rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_digit", 32'(out_digit), 32'(hold_digit));
          chk("hold_last", 32'(out_last), 32'(hold_last));
        end
        if (out_valid && out_ready) begin
          hs_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_digit: got 0x%0h, required none", out_digit);
          end else begin
            e = exp_q.pop_front();
            chk("digit", 32'(out_digit), 32'(e.digit));
            chk("last", 32'(out_last), 32'(e.last));
            if (e.last) chk("out_carry", 32'(out_carry), 32'(e.carry));
          end
        end
        hold = out_valid && !out_ready;
        hold_digit = out_digit;
        hold_last = out_last;
      end
    end
  end

  task automatic send_limb(input logic [19:0] c, input logic [19:0] s, input logic last);
    int k;
    int g;
    g = $urandom_range(0, gap_max);
    repeat (g) @(posedge clk);
    if (g != 0) #1;
    in_c = c;
    in_s = s;
    in_last = last;
    in_valid = 1'b1;
    k = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      k++;
      if (k > 300) break;
    end
    if (k > 300) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0, required 1 within 300 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Reference: the frame is one integer V = sum((C_i+S_i) << 16i); its digits
  // are V's base-2^16 digits and the final carry is V >> 16n.
  task automatic run_frame(input int n);
    logic [159:0] v;
    logic [159:0] fin;
    exp_t e;
    v = '0;
    for (int i = 0; i < n; i++) v = v + ((160'(fc[i]) + 160'(fs[i])) << (16 * i));
    fin = v >> (16 * n);
    for (int i = 0; i < n; i++) begin
      e.digit = v[16*i +: 16];
      e.last  = (!sel && (i == n - 1));
      e.carry = fin[5:0];
      exp_q.push_back(e);
    end
    if (sel) begin
      e.digit = fin[15:0];
      e.last  = 1'b1;
      e.carry = fin[5:0];
      exp_q.push_back(e);
    end
    for (int i = 0; i < n; i++) send_limb(fc[i], fs[i], (i == n - 1));
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d digits outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic random_frames(input int count);
    int n;
    for (int f = 0; f < count; f++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        fc[i] = ($urandom_range(0, 3) == 0) ? 20'hFFFFF : 20'($urandom_range(0, 20'hFFFFF));
        fs[i] = ($urandom_range(0, 3) == 0) ? 20'hFFFFF : 20'($urandom_range(0, 20'hFFFFF));
      end
      run_frame(n);
    end
    drain();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    or_mode = 0;
    gap_max = 0;
    mon_en = 1'b1;
    sel = 1'b1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_c = '0;
    in_s = '0;
    in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_digit", 32'(out_digit), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_carry", 32'(out_carry), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    sel = 1'b0;
    #1;
    chk("rst_busy_noemit", 32'(busy), 32'd0);
    chk("rst_carry_noemit", 32'(out_carry), 32'd0);
    sel = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single limb, final carry emitted
    fc[0] = 20'hFFFFF; fs[0] = 20'hFFFFF;
    run_frame(1);
    drain();
    chk("s1_out_carry", 32'(out_carry), 32'h1F);

    // 2: two limbs with carry propagation
    fc[0] = 20'h10000; fs[0] = 20'h0FFFF;
    fc[1] = 20'h00000; fs[1] = 20'h0FFFF;
    run_frame(2);
    drain();

    // 3: downstream stall during a 3-limb frame
    or_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    fc[0] = 20'hABCDE; fs[0] = 20'h54321;
    fc[1] = 20'hFFFFF; fs[1] = 20'h00001;
    fc[2] = 20'h12345; fs[2] = 20'hFEDCB;
    fork
      run_frame(3);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("s3_in_ready_stalled", 32'(in_ready), 32'd0);
        chk("s3_out_valid_stalled", 32'(out_valid), 32'd1);
        repeat (4) @(posedge clk);
        or_mode = 0;
      end
    join
    drain();

    // 4: back-to-back frames at full rate
    hs_cyc.delete();
    fc[0] = 20'hFFFFF; fs[0] = 20'hFFFFF;
    fc[1] = 20'h00007; fs[1] = 20'h00000;
    run_frame(2);
    fc[0] = 20'h00000; fs[0] = 20'h00005;
    run_frame(1);
    drain();
    chk("s4_digit_count", 32'(hs_cyc.size()), 32'd5);
    if (hs_cyc.size() == 5) chk("s4_no_bubble", 32'(hs_cyc[4] - hs_cyc[0]), 32'd4);

    // 5: reset mid-frame discards the partial frame and its carry
    mon_en = 1'b0;
    send_limb(20'h30000, 20'h00000, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("s5_out_valid_async", 32'(out_valid), 32'd0);
    chk("s5_busy_async", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    mon_en = 1'b1;
    fc[0] = 20'h00000; fs[0] = 20'h00001;
    run_frame(1);
    drain();

    // 6: final carry reported only on out_carry
    sel = 1'b0;
    fc[0] = 20'hFFFFF; fs[0] = 20'hFFFFF;
    run_frame(1);
    @(negedge clk);
    @(negedge clk);
    chk("s6_busy_after", 32'(busy), 32'd0);
    chk("s6_out_valid_after", 32'(out_valid), 32'd0);
    chk("s6_out_carry", 32'(out_carry), 32'h1F);
    drain();

    // random frames, random gaps and backpressure, both variants
    or_mode = 1;
    gap_max = 2;
    sel = 1'b1;
    random_frames(20);
    sel = 1'b0;
    random_frames(20);
    or_mode = 0;
    gap_max = 0;
    random_frames(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
